// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the FFT result unloader.
package fft_pkg;

  localparam int unsigned N_POINTS = 16;
  localparam int unsigned LOG2N    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } unload_state_t;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_unloader_toggle_detect.sv
// Frame toggle detector: registers the core's frame flag and flags any level change.
module toggle_detect (
  input  logic clk,
  input  logic rst,
  input  logic flag,
  output logic toggle
);

  logic flag_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flag_q <= 1'b0;
    else      flag_q <= flag;
  end

  assign toggle = flag ^ flag_q;

endmodule

// File: rtl/fft_result_unloader.sv
// Captures a 16-point complex FFT frame LATENCY edges after the core toggles its frame flag
// and streams it out over valid/ready. Define FFT_UNLOAD_BITREV_EN for bit-reversed read order.
module fft_result_unloader
  import fft_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       new_input_flag,
  input  logic [N_POINTS*DATA_W-1:0] fft_real,
  input  logic [N_POINTS*DATA_W-1:0] fft_imag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_real,
  output logic [DATA_W-1:0]          out_imag,
  output logic [LOG2N-1:0]           out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       clear_overrun
);

  localparam logic [7:0]       LAT_M1   = 8'(LATENCY - 1);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);
  localparam logic [LOG2N-1:0] FIRST    = '0;

  unload_state_t state, state_d;

  logic                             toggle;
  logic [7:0]                       cnt;
  logic [LOG2N-1:0]                 idx;
  logic [LOG2N-1:0]                 idx_nx;
  logic [LOG2N-1:0]                 first_sel;
  logic [LOG2N-1:0]                 next_sel;
  logic [N_POINTS-1:0][DATA_W-1:0]  in_re;
  logic [N_POINTS-1:0][DATA_W-1:0]  in_im;
  logic [N_POINTS-1:0][DATA_W-1:0]  frame_re;
  logic [N_POINTS-1:0][DATA_W-1:0]  frame_im;
  logic                             capture;
  logic                             advance;
  logic                             final_xfer;
  logic                             restart;
  logic                             set_ov;

  function automatic logic [LOG2N-1:0] order_sel(input logic [LOG2N-1:0] i);
`ifdef FFT_UNLOAD_BITREV_EN
    return bitrev4(i);
`else
    return i;
`endif
  endfunction

  toggle_detect u_toggle_detect (
    .clk    (clk),
    .rst    (rst),
    .flag   (new_input_flag),
    .toggle (toggle)
  );

  assign in_re     = fft_real;
  assign in_im     = fft_imag;
  assign idx_nx    = idx + 1'b1;
  assign first_sel = order_sel(FIRST);
  assign next_sel  = order_sel(idx_nx);
  assign out_valid = (state == STREAM);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d    = state;
    capture    = 1'b0;
    advance    = 1'b0;
    final_xfer = 1'b0;
    restart    = 1'b0;
    set_ov     = 1'b0;
    unique case (state)
      IDLE: begin
        if (toggle) begin
          state_d = WAIT;
          restart = 1'b1;
        end
      end
      WAIT: begin
        // A newer frame supersedes the pending one, even on the capture edge.
        if (toggle) begin
          restart = 1'b1;
          set_ov  = 1'b1;
        end else if (cnt == LAT_M1) begin
          state_d = STREAM;
          capture = 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            final_xfer = 1'b1;
            if (toggle) begin
              state_d = WAIT;
              restart = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        if (toggle && !final_xfer) set_ov = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      idx       <= '0;
      frame_re  <= '0;
      frame_im  <= '0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (restart)             cnt <= '0;
      else if (state == WAIT)  cnt <= cnt + 8'd1;

      // Output registers are preloaded with the next element so they stay stable under stall.
      if (capture) begin
        frame_re  <= in_re;
        frame_im  <= in_im;
        idx       <= '0;
        out_real  <= in_re[first_sel];
        out_imag  <= in_im[first_sel];
        out_index <= first_sel;
        out_last  <= 1'b0;
      end else if (advance) begin
        idx       <= idx_nx;
        out_real  <= frame_re[next_sel];
        out_imag  <= frame_im[next_sel];
        out_index <= next_sel;
        out_last  <= (idx_nx == LAST_IDX);
      end else if (final_xfer) begin
        idx       <= '0;
        out_last  <= 1'b0;
      end

      if (set_ov)             overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

endmodule
